// File: rtl/trace_addr_feeder.sv
// rtl/trace_addr_feeder.sv - delta-to-address feeder with FIFO and run-length FSM
//
// Accumulates a stream of signed trace deltas into absolute byte addresses
// and presents them, one per cycle, to the cache address port. The first
// delta of a run is the base address. A small FIFO absorbs cache-side
// backpressure; a run-length FSM tags the final address and raises done.
//
// Ports:
//   clk, rst_n      clock (rising edge), asynchronous active-low reset
//   start           one-cycle pulse: flush and begin a new run
//   trace_len       number of deltas in the run, sampled on start
//   delta_valid/delta_ready/delta
//                   delta input handshake (signed two's-complement delta)
//   addr_valid/addr_ready/addr/addr_last
//                   address output handshake, addr_last marks the final address
//   issued_count    addresses popped this run (saturating)
//   busy            run in progress (RUN or DRAIN)
//   done            run complete, held until next start
//   wrap            sticky: an accumulation wrapped modulo 2^ADDR_W
module trace_addr_feeder #(
  parameter int ADDR_W     = 32,
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_W      = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [CNT_W-1:0]  trace_len,
  input  logic              delta_valid,
  output logic              delta_ready,
  input  logic [ADDR_W-1:0] delta,
  output logic              addr_valid,
  input  logic              addr_ready,
  output logic [ADDR_W-1:0] addr,
  output logic              addr_last,
  output logic [CNT_W-1:0]  issued_count,
  output logic              busy,
  output logic              done,
  output logic              wrap
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int OCC_W = PTR_W + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t state, state_nxt;

  // Each entry carries the last-of-run tag in its MSB.
  logic [ADDR_W:0]   mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [OCC_W-1:0]  occ;
  logic              fifo_full, fifo_empty;

  logic [CNT_W-1:0]  len_q;
  logic [CNT_W-1:0]  accepted;
  logic [ADDR_W-1:0] acc;
  logic              first;

  logic              run_active;
  logic              push, pop;
  logic [ADDR_W-1:0] value;
  logic              is_last;
  logic              wrap_now;
  logic [ADDR_W:0]   head;

  assign fifo_full  = (occ == OCC_W'(FIFO_DEPTH));
  assign fifo_empty = (occ == '0);
  assign run_active = (state == S_RUN) || (state == S_DRAIN);

  // Full is taken from the occupancy register only, so a simultaneous pop
  // never opens a slot for a push. start blocks acceptance so a delta is
  // never handshaken in the same cycle the run is being flushed.
  assign delta_ready = (state == S_RUN) && !fifo_full && (accepted < len_q) && !start;
  assign push        = delta_valid && delta_ready;

  assign addr_valid  = run_active && !fifo_empty;
  assign pop         = addr_valid && addr_ready;

  assign head        = mem[rd_ptr];
  assign addr        = addr_valid ? head[ADDR_W-1:0] : '0;
  assign addr_last   = addr_valid ? head[ADDR_W] : 1'b0;

  assign busy        = run_active;
  assign done        = (state == S_DONE);

  // First delta of a run is the base address itself.
  assign value   = first ? delta : (acc + delta);
  assign is_last = (accepted == (len_q - CNT_W'(1)));

  // Unsigned compare against the old accumulator: a non-negative delta that
  // lands below it, or a negative delta that lands above it, crossed 2^ADDR_W.
  assign wrap_now = !first && (delta[ADDR_W-1] ? (value > acc) : (value < acc));

  always_comb begin
    state_nxt = state;
    case (state)
      S_RUN:   if (push && is_last) state_nxt = S_DRAIN;
      S_DRAIN: if (pop && addr_last) state_nxt = S_DONE;
      default: state_nxt = state;
    endcase
    if (start) begin
      state_nxt = (trace_len != '0) ? S_RUN : S_DONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      occ          <= '0;
      len_q        <= '0;
      accepted     <= '0;
      acc          <= '0;
      first        <= 1'b1;
      issued_count <= '0;
      wrap         <= 1'b0;
    end else if (start) begin
      // Flush: in-flight entries are dropped by resetting the pointers.
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      occ          <= '0;
      len_q        <= trace_len;
      accepted     <= '0;
      first        <= 1'b1;
      issued_count <= '0;
      wrap         <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr   <= wr_ptr + PTR_W'(1);
        acc      <= value;
        accepted <= accepted + CNT_W'(1);
        first    <= 1'b0;
        if (wrap_now) wrap <= 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
        if (issued_count != '1) issued_count <= issued_count + CNT_W'(1);
      end
      case ({push, pop})
        2'b10:   occ <= occ + OCC_W'(1);
        2'b01:   occ <= occ - OCC_W'(1);
        default: occ <= occ;
      endcase
    end
  end

  // Storage needs no reset: an entry is only visible after it is written.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {is_last, value};
    end
  end

endmodule

// File: tb/tb_trace_addr_feeder.sv
// tb/tb_trace_addr_feeder.sv - scoreboard bench for trace_addr_feeder
module tb_trace_addr_feeder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] trace_len = '0;
  logic        delta_valid = 1'b0;
  logic        delta_ready;
  logic [31:0] delta = '0;
  logic        addr_valid;
  logic        addr_ready = 1'b0;
  logic [31:0] addr;
  logic        addr_last;
  logic [31:0] issued_count;
  logic        busy;
  logic        done;
  logic        wrap;

  int n_checks = 0;
  int n_errors = 0;

  logic [32:0] exp_q[$];
  logic [31:0] dq[$];

  // Reference model: running absolute address kept as a wide integer.
  longint m_prev;
  bit     m_first;
  int     m_acc;
  int     m_len;
  bit     m_wrap;

  // Monitor state.
  int          mon_issued;
  bit          done_pend;
  bit          hold;
  logic [31:0] hold_addr;

  always #5 clk = ~clk;

  trace_addr_feeder #(.ADDR_W(32), .FIFO_DEPTH(8), .CNT_W(32)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .trace_len    (trace_len),
    .delta_valid  (delta_valid),
    .delta_ready  (delta_ready),
    .delta        (delta),
    .addr_valid   (addr_valid),
    .addr_ready   (addr_ready),
    .addr         (addr),
    .addr_last    (addr_last),
    .issued_count (issued_count),
    .busy         (busy),
    .done         (done),
    .wrap         (wrap)
  );

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_accept(input logic [31:0] d);
    longint      s;
    longint      lim;
    logic [31:0] v;
    bit          last;
    lim = 64'd4294967295;
    if (m_first) begin
      v = d;
      m_first = 0;
    end else begin
      s = m_prev + longint'($signed(d));
      if (s < 0 || s > lim) m_wrap = 1;
      v = s[31:0];
    end
    m_prev = {32'd0, v};
    last = (m_acc == m_len - 1);
    m_acc++;
    exp_q.push_back({last, v});
  endtask

  function automatic logic [31:0] rand_delta();
    logic [31:0] v;
    case ($urandom_range(3))
      0: v = $urandom();
      1: v = 32'($urandom_range(0, 64));
      2: begin v = 32'($urandom_range(1, 64)); v = -v; end
      default: v = 32'hFFFF_FF00 + 32'($urandom_range(0, 255));
    endcase
    return v;
  endfunction

  // Monitor: pops the expected entry whenever the DUT hands out an address.
  always @(negedge clk) begin
    if (!rst_n || start) begin
      exp_q.delete();
      mon_issued = 0;
      done_pend = 0;
      hold = 0;
    end else begin
      if (done_pend) begin
        chk("done_after_last_pop", done, 1);
        done_pend = 0;
      end
      chk("issued_count", issued_count, mon_issued);
      if (hold && addr_valid) chk("addr_stable", addr, hold_addr);
      if (addr_valid && addr_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_addr", addr_valid, 0);
        end else begin
          logic [32:0] e;
          e = exp_q.pop_front();
          chk("addr", addr, e[31:0]);
          chk("addr_last", addr_last, e[32]);
          if (e[32]) done_pend = 1;
        end
        mon_issued++;
      end
      hold = addr_valid && !addr_ready;
      hold_addr = addr;
    end
  end

  task automatic start_run(input int len);
    @(posedge clk); #1;
    start = 1; trace_len = len; delta_valid = 0; addr_ready = 0;
    @(negedge clk);
    m_first = 1; m_prev = 0; m_acc = 0; m_len = len; m_wrap = 0;
    @(posedge clk); #1;
    start = 0;
    @(negedge clk);
    chk("start_wrap_clr", wrap, 0);
    chk("start_done", done, len == 0);
    chk("start_busy", busy, len != 0);
  endtask

  task automatic run_cycles(input int max_cyc, input int vp, input int rp,
                            input bit until_done, input int until_issued);
    for (int c = 0; c < max_cyc; c++) begin
      @(posedge clk); #1;
      delta_valid = (dq.size() > 0) && ($urandom_range(99) < vp);
      delta = (dq.size() > 0) ? dq[0] : $urandom();
      addr_ready = ($urandom_range(99) < rp);
      @(negedge clk);
      if (delta_valid && delta_ready) begin
        model_accept(delta);
        void'(dq.pop_front());
      end
      if (until_done && done) return;
      if (until_issued > 0 && int'(issued_count) >= until_issued) return;
    end
    if (until_done) chk("run_timeout_done", done, 1);
  endtask

  task automatic end_checks(input int len);
    chk("end_issued_count", issued_count, len);
    chk("end_done", done, 1);
    chk("end_busy", busy, 0);
    chk("end_wrap", wrap, m_wrap);
    chk("end_queue_drained", exp_q.size(), 0);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_delta_ready"}, delta_ready, 0);
    chk({tag, "_addr_valid"}, addr_valid, 0);
    chk({tag, "_addr"}, addr, 0);
    chk({tag, "_addr_last"}, addr_last, 0);
    chk({tag, "_issued_count"}, issued_count, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_wrap"}, wrap, 0);
  endtask

  initial begin
    int len;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    @(posedge clk); #2;
    rst_n = 1;

    // IDLE ignores delta_valid.
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      delta_valid = 1;
      @(negedge clk);
      chk("idle_delta_ready", delta_ready, 0);
    end
    delta_valid = 0;

    // Basic run: 100, 104, 96.
    dq.delete();
    dq.push_back(32'd100); dq.push_back(32'd4); dq.push_back(32'hFFFF_FFF8);
    start_run(3);
    run_cycles(30, 100, 100, 1, 0);
    end_checks(3);
    chk("t1_wrap", wrap, 0);

    // Backpressure: FIFO fills at 8 entries, head holds base 0.
    dq.delete();
    dq.push_back(32'd0);
    repeat (9) dq.push_back(32'd4);
    start_run(10);
    run_cycles(14, 100, 0, 0, 0);
    chk("t2_ready_when_full", delta_ready, 0);
    chk("t2_valid_held", addr_valid, 1);
    chk("t2_addr_held", addr, 0);
    chk("t2_accepted", 10 - dq.size(), 8);
    run_cycles(60, 100, 100, 1, 0);
    end_checks(10);

    // Wrap past 2^32.
    dq.delete();
    dq.push_back(32'hFFFF_FFF0); dq.push_back(32'h20);
    start_run(2);
    run_cycles(30, 100, 100, 1, 0);
    end_checks(2);
    chk("t3_wrap_set", wrap, 1);
    run_cycles(3, 100, 100, 0, 0);
    chk("t3_wrap_sticky", wrap, 1);

    // Zero-length run goes straight to DONE.
    dq.delete();
    start_run(0);
    run_cycles(5, 100, 100, 0, 0);
    chk("t4_addr_valid", addr_valid, 0);
    chk("t4_done", done, 1);
    chk("t4_issued", issued_count, 0);

    // Abort mid-run, then a fresh run must see no stale entries.
    dq.delete();
    repeat (6) dq.push_back(32'($urandom_range(0, 255)));
    start_run(6);
    run_cycles(40, 100, 100, 0, 3);
    chk("t5_busy_at_abort", busy, 1);
    dq.delete();
    repeat (4) dq.push_back(rand_delta());
    start_run(4);
    run_cycles(60, 80, 70, 1, 0);
    end_checks(4);

    // Randomized runs.
    for (int r = 0; r < 12; r++) begin
      len = $urandom_range(1, 20);
      dq.delete();
      for (int i = 0; i < len; i++) dq.push_back(rand_delta());
      start_run(len);
      run_cycles(600, $urandom_range(30, 100), $urandom_range(20, 100), 1, 0);
      end_checks(len);
    end

    // Asynchronous reset in the middle of a run.
    dq.delete();
    repeat (8) dq.push_back(rand_delta());
    start_run(8);
    run_cycles(6, 100, 0, 0, 0);
    chk("pre_reset_valid", addr_valid, 1);
    @(posedge clk); #3;
    rst_n = 0;
    #1;
    check_all_zero("async_reset");
    dq.delete();
    delta_valid = 1;
    @(posedge clk); #2;
    rst_n = 1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("post_reset_delta_ready", delta_ready, 0);
      chk("post_reset_busy", busy, 0);
    end
    delta_valid = 0;

    dq.delete();
    repeat (5) dq.push_back(rand_delta());
    start_run(5);
    run_cycles(100, 90, 90, 1, 0);
    end_checks(5);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
